// File: rtl/accel_pkg.sv
// Shared types and default constants for the calibrating accelerometer scaler.
package accel_pkg;

   // Calibration FSM: normal scaling or offset averaging.
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_CAL = 1'b1
   } cal_state_e;

   // Reset scale: 0.001 in Q0.20.
   localparam logic [19:0] SCALE_0P001 = 20'h00419;

   // Default per-axis offsets (X = -40, Y = 0, Z = -784).
   localparam logic [15:0] OFFS_X_DEF = 16'hffd8;
   localparam logic [15:0] OFFS_Y_DEF = 16'h0000;
   localparam logic [15:0] OFFS_Z_DEF = 16'hfcf0;
   localparam logic [47:0] OFFS_DEF   = {OFFS_Z_DEF, OFFS_Y_DEF, OFFS_X_DEF};

   // Channel positions inside packed buses (channel 0 in the LSBs).
   localparam int CH_X = 0;
   localparam int CH_Y = 1;
   localparam int CH_Z = 2;

endpackage

// File: rtl/accel_scale_lane.sv
// One channel of the scaler: subtract offset, absolute value, scale and saturate.
// Stage enables come from the shared valid pipeline in the top.
module accel_scale_lane #(
   parameter int DIN_W   = 16,
   parameter int SCALE_W = 20,
   parameter int OUT_W   = 24
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en1,
   input  logic               i_en2,
   input  logic               i_en3,
   input  logic [DIN_W-1:0]   i_sample,
   input  logic [DIN_W-1:0]   i_offs,
   input  logic [SCALE_W-1:0] i_scale,
   output logic [OUT_W-1:0]   o_data,
   output logic               o_sign,
   output logic               o_sat
);

   localparam int PROD_W = DIN_W + 1 + SCALE_W;

   logic [DIN_W:0]    diff_q, diff_d;
   logic [DIN_W:0]    mag_q, mag_d;
   logic              neg_q, neg_d;
   logic [OUT_W-1:0]  data_q, data_d;
   logic              sign_q, sign_d;
   logic              sat_q, sat_d;
   logic [PROD_W-1:0] prod;

   // Next-state for all three stages; each stage only moves when its enable is set.
   always_comb begin
      diff_d = diff_q;
      mag_d  = mag_q;
      neg_d  = neg_q;
      data_d = data_q;
      sign_d = sign_q;
      sat_d  = sat_q;
      prod   = {{SCALE_W{1'b0}}, mag_q} * {{(DIN_W+1){1'b0}}, i_scale};
      // One extra bit keeps the difference from wrapping.
      if (i_en1) begin
         diff_d = {i_sample[DIN_W-1], i_sample} - {i_offs[DIN_W-1], i_offs};
      end
      // Magnitude of -2^DIN_W still fits as an unsigned DIN_W+1 value.
      if (i_en2) begin
         neg_d = diff_q[DIN_W];
         mag_d = diff_q[DIN_W] ? -diff_q : diff_q;
      end
      if (i_en3) begin
         sign_d = neg_q;
         sat_d  = |prod[PROD_W-1:OUT_W];
         data_d = sat_d ? '1 : prod[OUT_W-1:0];
      end
   end

   // Pipeline and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         diff_q <= '0;
         mag_q  <= '0;
         neg_q  <= 1'b0;
         data_q <= '0;
         sign_q <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         diff_q <= diff_d;
         mag_q  <= mag_d;
         neg_q  <= neg_d;
         data_q <= data_d;
         sign_q <= sign_d;
         sat_q  <= sat_d;
      end
   end

   assign o_data = data_q;
   assign o_sign = sign_q;
   assign o_sat  = sat_q;

endmodule

// File: rtl/accel_scaler_cal.sv
// Multi-channel offset/scale/saturate front end with on-demand offset calibration.
// Valid is a one-cycle strobe with no backpressure: o_valid rises exactly three
// cycles after each sample accepted while the FSM is in RUN.
module accel_scaler_cal
   import accel_pkg::*;
#(
   parameter int                      NUM_CH     = 3,
   parameter int                      DIN_W      = 16,
   parameter int                      SCALE_W    = 20,
   parameter int                      OUT_W      = 24,
   parameter int                      CAL_LOG2   = 4,
   parameter logic [SCALE_W-1:0]      SCALE_INIT = SCALE_0P001,
   parameter logic [NUM_CH*DIN_W-1:0] OFFS_INIT  = OFFS_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   input  logic [NUM_CH*DIN_W-1:0] i_data,
   input  logic [SCALE_W-1:0]      i_scale,
   input  logic                    i_scale_we,
   input  logic                    i_cal_start,
   output logic                    o_valid,
   output logic [NUM_CH*OUT_W-1:0] o_data,
   output logic [NUM_CH-1:0]       o_sign,
   output logic [NUM_CH-1:0]       o_sat,
   output logic                    o_cal_busy,
   output logic                    o_cal_done
);

   localparam int ACC_W = DIN_W + CAL_LOG2;

   cal_state_e                state_q, state_d;
   logic [SCALE_W-1:0]        scale_q, scale_d;
   logic [NUM_CH*DIN_W-1:0]   offs_q, offs_d;
   logic [NUM_CH*ACC_W-1:0]   acc_q, acc_d;
   logic [CAL_LOG2-1:0]       cnt_q, cnt_d;
   logic                      cal_done_q, cal_done_d;
   logic                      v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
   logic [ACC_W-1:0]          acc_sum [NUM_CH];

   // Running sum of each channel including the sample currently on the input.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         acc_sum[c] = acc_q[c*ACC_W +: ACC_W]
                    + {{CAL_LOG2{i_data[c*DIN_W+DIN_W-1]}}, i_data[c*DIN_W +: DIN_W]};
      end
   end

   // FSM next state, calibration accumulation/commit, scale load and valid pipeline.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      offs_d     = offs_q;
      cal_done_d = 1'b0;
      scale_d    = i_scale_we ? i_scale : scale_q;
      v1_d       = i_valid && (state_q == ST_RUN);
      v2_d       = v1_q;
      ov_d       = v2_q;
      case (state_q)
         ST_RUN: begin
            if (i_cal_start) begin
               state_d = ST_CAL;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         ST_CAL: begin
            // Further i_cal_start pulses are ignored here.
            if (i_valid) begin
               cnt_d = cnt_q + CAL_LOG2'(1);
               for (int c = 0; c < NUM_CH; c++) begin
                  acc_d[c*ACC_W +: ACC_W] = acc_sum[c];
               end
               // Last sample: the top DIN_W bits are the arithmetic-shift average.
               if (&cnt_q) begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     offs_d[c*DIN_W +: DIN_W] = acc_sum[c][ACC_W-1 -: DIN_W];
                  end
                  state_d    = ST_RUN;
                  cal_done_d = 1'b1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Control and configuration registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_RUN;
         scale_q    <= SCALE_INIT;
         offs_q     <= OFFS_INIT;
         acc_q      <= '0;
         cnt_q      <= '0;
         cal_done_q <= 1'b0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         ov_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         scale_q    <= scale_d;
         offs_q     <= offs_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         cal_done_q <= cal_done_d;
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         ov_q       <= ov_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      accel_scale_lane #(
         .DIN_W   (DIN_W),
         .SCALE_W (SCALE_W),
         .OUT_W   (OUT_W)
      ) u_lane (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_en1    (v1_d),
         .i_en2    (v1_q),
         .i_en3    (v2_q),
         .i_sample (i_data[g*DIN_W +: DIN_W]),
         .i_offs   (offs_q[g*DIN_W +: DIN_W]),
         .i_scale  (scale_q),
         .o_data   (o_data[g*OUT_W +: OUT_W]),
         .o_sign   (o_sign[g]),
         .o_sat    (o_sat[g])
      );
   end

   assign o_valid    = ov_q;
   assign o_cal_busy = (state_q == ST_CAL);
   assign o_cal_done = cal_done_q;

endmodule
